// File: rtl/mem_ctrl_if.sv
// Load/store handshake between the execute stage (master) and the memory-port controller (slave).
interface mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              ls_req;
  logic              ls_we;
  logic [1:0]        ls_size;
  logic              ls_signed;
  logic [ADDR_W-1:0] ls_addr;
  logic [31:0]       ls_wdata;
  logic              ls_ack;
  logic              ls_err;
  logic [31:0]       ls_rdata;

  modport master (
    output ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    input  ls_ack, ls_err, ls_rdata
  );

  modport slave (
    input  ls_req, ls_we, ls_size, ls_signed, ls_addr, ls_wdata,
    output ls_ack, ls_err, ls_rdata
  );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port memory controller: instruction fetch every idle cycle, load/store arbitration with lane steering.
// Optional feature: define MEMCTL_SIGNEXT_EN to sign-extend loads that request it.
module mem_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] pc,
  output logic              stall,
  output logic [31:0]       instr_data,
  output logic              fetch_valid,
  mem_ctrl_if.slave         ls,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [2:0] {IDLE, FETCH, DATA, RDATA, ERR} state_t;

  state_t            state_q, state_d;
  logic              sel_q, sel_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              we_q, we_d;
  logic [1:0]        size_q, size_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
`ifdef MEMCTL_SIGNEXT_EN
  logic              signed_q, signed_d;
`else
  logic              unused_signed;
  assign unused_signed = ls.ls_signed;
`endif

  logic              illegal;
  logic [3:0]        data_be;
  logic [31:0]       data_wdata;
  logic [31:0]       shifted;
  logic [31:0]       load_data;
  logic [ADDR_W-1:0] fetch_addr;
  logic              unused_pc0;

  assign fetch_addr  = {pc[ADDR_W-1:2], 2'b00};
  assign unused_pc0  = pc[0];
  assign fetch_valid = fetch_valid_q;
  assign instr_data  = !fetch_valid_q ? 32'h0 :
                       (sel_q ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]});

  always_comb begin
    illegal = 1'b0;
    case (ls.ls_size)
      2'b01:   illegal = ls.ls_addr[0];
      2'b10:   illegal = |ls.ls_addr[1:0];
      2'b11:   illegal = 1'b1;
      default: illegal = 1'b0;
    endcase
  end

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    case (size_q)
      2'b00: begin
        data_be    = 4'b0001 << addr_q[1:0];
        data_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        data_be    = addr_q[1] ? 4'b1100 : 4'b0011;
        data_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        data_be    = 4'hF;
        data_wdata = wdata_q;
      end
    endcase
  end

  always_comb begin
    shifted = mem_rdata >> {addr_q[1:0], 3'b000};
    case (size_q)
      2'b00:   load_data = {24'h0, shifted[7:0]};
      2'b01:   load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
`ifdef MEMCTL_SIGNEXT_EN
    if (signed_q) begin
      if (size_q == 2'b00)
        load_data = {{24{shifted[7]}}, shifted[7:0]};
      else if (size_q == 2'b01)
        load_data = {{16{shifted[15]}}, shifted[15:0]};
    end
`endif
  end

  always_comb begin
    state_d       = state_q;
    sel_d         = sel_q;
    fetch_valid_d = 1'b0;
    we_d          = we_q;
    size_d        = size_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
`ifdef MEMCTL_SIGNEXT_EN
    signed_d      = signed_q;
`endif
    stall         = 1'b1;
    mem_en        = 1'b0;
    mem_we        = 1'b0;
    mem_be        = 4'h0;
    mem_addr      = '0;
    mem_wdata     = 32'h0;
    ls.ls_ack     = 1'b0;
    ls.ls_err     = 1'b0;
    ls.ls_rdata   = 32'h0;
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_en        = 1'b1;
        mem_be        = 4'hF;
        mem_addr      = fetch_addr;
        sel_d         = pc[1];
        fetch_valid_d = 1'b1;
        stall         = ls.ls_req;
        if (ls.ls_req) begin
          we_d    = ls.ls_we;
          size_d  = ls.ls_size;
          addr_d  = ls.ls_addr;
          wdata_d = ls.ls_wdata;
`ifdef MEMCTL_SIGNEXT_EN
          signed_d = ls.ls_signed;
`endif
          state_d = illegal ? ERR : DATA;
        end
      end
      DATA: begin
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
        mem_be    = data_be;
        mem_wdata = data_wdata;
        if (we_q) begin
          ls.ls_ack = 1'b1;
          state_d   = FETCH;
        end else begin
          state_d   = RDATA;
        end
      end
      // The fetch is re-issued here so fetch_valid resumes right after the load completes.
      RDATA: begin
        ls.ls_ack     = 1'b1;
        ls.ls_rdata   = load_data;
        mem_en        = 1'b1;
        mem_be        = 4'hF;
        mem_addr      = fetch_addr;
        sel_d         = pc[1];
        fetch_valid_d = 1'b1;
        state_d       = FETCH;
      end
      ERR: begin
        ls.ls_ack = 1'b1;
        ls.ls_err = 1'b1;
        state_d   = FETCH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      sel_q         <= 1'b0;
      fetch_valid_q <= 1'b0;
      we_q          <= 1'b0;
      size_q        <= 2'b00;
      addr_q        <= '0;
      wdata_q       <= 32'h0;
`ifdef MEMCTL_SIGNEXT_EN
      signed_q      <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      sel_q         <= sel_d;
      fetch_valid_q <= fetch_valid_d;
      we_q          <= we_d;
      size_q        <= size_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
`ifdef MEMCTL_SIGNEXT_EN
      signed_q      <= signed_d;
`endif
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected load/store responses queued at request time, checked on ls_ack.
module tb_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc;
  logic        stall;
  logic [31:0] instr_data;
  logic        fetch_valid;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_ctrl_if #(.ADDR_W(32)) ls_bus ();

  mem_ctrl #(.ADDR_W(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pc          (pc),
    .stall       (stall),
    .instr_data  (instr_data),
    .fetch_valid (fetch_valid),
    .ls          (ls_bus),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_be      (mem_be),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  typedef struct packed {
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbq[$];
  int   n_checks = 0;
  int   n_errors = 0;

`ifdef MEMCTL_SIGNEXT_EN
  localparam logic [31:0] EXP_SB_80   = 32'hFFFFFF80;
  localparam logic [31:0] EXP_SB_C3   = 32'hFFFFFFC3;
  localparam logic [31:0] EXP_SH_80A1 = 32'hFFFF80A1;
`else
  localparam logic [31:0] EXP_SB_80   = 32'h00000080;
  localparam logic [31:0] EXP_SB_C3   = 32'h000000C3;
  localparam logic [31:0] EXP_SH_80A1 = 32'h000080A1;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous memory model: one-cycle read latency, byte-enabled writes, preloaded on first edge.
  logic [31:0] mem_model [0:255];
  bit          preloaded = 1'b0;
  initial mem_rdata = 32'h0;
  always @(posedge clk) begin
    if (!preloaded) begin
      for (int i = 0; i < 256; i++) mem_model[i] = 32'h0;
      mem_model[64]  = 32'h11223344;
      mem_model[128] = 32'h80A1B2C3;
      preloaded = 1'b1;
    end
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_model[mem_addr[9:2]][8*b +: 8] = mem_wdata[8*b +: 8];
      end
      mem_rdata <= mem_model[mem_addr[9:2]];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Every completion is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && ls_bus.ls_ack) begin
      if (sbq.size() == 0) begin
        checkOutput("sb_pending", 32'(sbq.size()), 32'd1);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        checkOutput("sb_err", {31'h0, ls_bus.ls_err}, {31'h0, e.err});
        checkOutput("sb_rdata", ls_bus.ls_rdata, e.rdata);
      end
    end
  end

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_stall"}, {31'h0, stall}, 32'd1);
    checkOutput({tag, "_mem_en"}, {31'h0, mem_en}, 32'd0);
    checkOutput({tag, "_mem_we"}, {31'h0, mem_we}, 32'd0);
    checkOutput({tag, "_mem_be"}, {28'h0, mem_be}, 32'd0);
    checkOutput({tag, "_mem_addr"}, mem_addr, 32'd0);
    checkOutput({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    checkOutput({tag, "_fetch_valid"}, {31'h0, fetch_valid}, 32'd0);
    checkOutput({tag, "_instr_data"}, instr_data, 32'd0);
    checkOutput({tag, "_ack"}, {31'h0, ls_bus.ls_ack}, 32'd0);
    checkOutput({tag, "_err"}, {31'h0, ls_bus.ls_err}, 32'd0);
    checkOutput({tag, "_rdata"}, ls_bus.ls_rdata, 32'd0);
  endtask

  task automatic waitFetch(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (mem_en && !mem_we && !stall) found = 1'b1;
    end
    checkOutput({tag, "_fetch_wait"}, {31'h0, found}, 32'd1);
  endtask

  task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                               input logic sgn, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic exp_err, input logic [31:0] exp_rdata,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata);
    int lat;
    bit got;
    int exp_lat;
    waitFetch(tag);
    ls_bus.ls_req    = 1'b1;
    ls_bus.ls_we     = we;
    ls_bus.ls_size   = size;
    ls_bus.ls_signed = sgn;
    ls_bus.ls_addr   = addr;
    ls_bus.ls_wdata  = wdata;
    sbq.push_back('{err: exp_err, rdata: exp_rdata});
    exp_lat = (exp_err || we) ? 1 : 2;
    #1 checkOutput({tag, "_stall_req"}, {31'h0, stall}, 32'd1);
    lat = 0;
    got = 1'b0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        if (exp_err) begin
          checkOutput({tag, "_no_mem_en"}, {31'h0, mem_en}, 32'd0);
          checkOutput({tag, "_no_mem_we"}, {31'h0, mem_we}, 32'd0);
        end else begin
          checkOutput({tag, "_mem_en"}, {31'h0, mem_en}, 32'd1);
          checkOutput({tag, "_mem_we"}, {31'h0, mem_we}, {31'h0, we});
          checkOutput({tag, "_mem_addr"}, mem_addr, {addr[31:2], 2'b00});
          checkOutput({tag, "_mem_be"}, {28'h0, mem_be}, {28'h0, exp_be});
          if (we) checkOutput({tag, "_mem_wdata"}, mem_wdata, exp_wdata);
        end
      end
      checkOutput({tag, "_stall_busy"}, {31'h0, stall}, 32'd1);
      if (ls_bus.ls_ack) got = 1'b1;
    end
    checkOutput({tag, "_ack_latency"}, 32'(lat), 32'(exp_lat));
    ls_bus.ls_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n            = 1'b0;
    pc               = 32'h102;
    ls_bus.ls_req    = 1'b0;
    ls_bus.ls_we     = 1'b0;
    ls_bus.ls_size   = 2'b00;
    ls_bus.ls_signed = 1'b0;
    ls_bus.ls_addr   = 32'h0;
    ls_bus.ls_wdata  = 32'h0;

    repeat (3) @(negedge clk);
    checkResetOutputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("first_fetch_en", {31'h0, mem_en}, 32'd1);
    checkOutput("first_fetch_addr", mem_addr, 32'h100);
    checkOutput("first_fetch_valid_low", {31'h0, fetch_valid}, 32'd0);
    @(negedge clk);
    checkOutput("fetch_valid", {31'h0, fetch_valid}, 32'd1);
    checkOutput("fetch_upper_half", instr_data, 32'h00001122);

    applyStimulus("st_byte", 1'b1, 2'b00, 1'b0, 32'h101, 32'h000000AB, 1'b0, 32'h0, 4'b0010, 32'hABABABAB);
    @(negedge clk);
    checkOutput("st_byte_stall_release", {31'h0, stall}, 32'd0);
    checkOutput("st_byte_fetch_gap", {31'h0, fetch_valid}, 32'd0);
    checkOutput("st_byte_mem", mem_model[64], 32'h1122AB44);

    applyStimulus("ld_half", 1'b0, 2'b01, 1'b0, 32'h102, 32'h0, 1'b0, 32'h00001122, 4'b1100, 32'h0);
    @(negedge clk);
    checkOutput("ld_half_fetch_resume", {31'h0, fetch_valid}, 32'd1);
    checkOutput("ld_half_instr", instr_data, 32'h00001122);

    pc = 32'h100;
    @(negedge clk);
    checkOutput("fetch_lower_half", instr_data, 32'h0000AB44);

    applyStimulus("err_word", 1'b0, 2'b10, 1'b0, 32'h102, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
    @(negedge clk);
    checkOutput("err_fetch_gap", {31'h0, fetch_valid}, 32'd0);
    applyStimulus("err_half", 1'b1, 2'b01, 1'b0, 32'h201, 32'h1234, 1'b1, 32'h0, 4'h0, 32'h0);
    applyStimulus("err_size", 1'b0, 2'b11, 1'b0, 32'h200, 32'h0, 1'b1, 32'h0, 4'h0, 32'h0);
    checkOutput("err_half_no_write", mem_model[128], 32'h80A1B2C3);

    applyStimulus("ld_sbyte3", 1'b0, 2'b00, 1'b1, 32'h203, 32'h0, 1'b0, EXP_SB_80, 4'b1000, 32'h0);
    applyStimulus("ld_sbyte0", 1'b0, 2'b00, 1'b1, 32'h200, 32'h0, 1'b0, EXP_SB_C3, 4'b0001, 32'h0);
    applyStimulus("ld_shalf", 1'b0, 2'b01, 1'b1, 32'h202, 32'h0, 1'b0, EXP_SH_80A1, 4'b1100, 32'h0);
    applyStimulus("ld_ubyte1", 1'b0, 2'b00, 1'b0, 32'h201, 32'h0, 1'b0, 32'h000000B2, 4'b0010, 32'h0);
    applyStimulus("ld_word", 1'b0, 2'b10, 1'b1, 32'h200, 32'h0, 1'b0, 32'h80A1B2C3, 4'hF, 32'h0);

    applyStimulus("st_word", 1'b1, 2'b10, 1'b0, 32'h204, 32'hDEADBEEF, 1'b0, 32'h0, 4'hF, 32'hDEADBEEF);
    applyStimulus("st_half", 1'b1, 2'b01, 1'b0, 32'h206, 32'h00001234, 1'b0, 32'h0, 4'b1100, 32'h12341234);
    applyStimulus("ld_back", 1'b0, 2'b10, 1'b0, 32'h204, 32'h0, 1'b0, 32'h1234BEEF, 4'hF, 32'h0);

    // Reset lands while the store is in its data cycle; the write must never happen.
    waitFetch("midrst");
    ls_bus.ls_req   = 1'b1;
    ls_bus.ls_we    = 1'b1;
    ls_bus.ls_size  = 2'b10;
    ls_bus.ls_addr  = 32'h208;
    ls_bus.ls_wdata = 32'h55555555;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 checkResetOutputs("midrst");
    ls_bus.ls_req = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("midrst_no_write", mem_model[130], 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midrst_refetch_en", {31'h0, mem_en}, 32'd1);
    checkOutput("midrst_refetch_addr", mem_addr, 32'h100);
    @(negedge clk);
    checkOutput("midrst_fetch_valid", {31'h0, fetch_valid}, 32'd1);

    checkOutput("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Memory-port controller that owns the single 32-bit synchronous memory port, the driving end of the instruction-fetch path. Each idle cycle it issues a word read at the current PC and presents the selected halfword to the fetch stage. It arbitrates load/store requests from execute, performs byte-lane steering, and stalls PC advance while a data access holds the port.

## Interface
Parameters:
- ADDR_W, 32, byte-address width of pc, ls_addr, mem_addr.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- pc  in  ADDR_W  current PC from register file.
- stall  out  1  hold PC; register file must not increment while high.
- instr_data  out  32  drives fetch stage data input; [15:0] hold the halfword at the fetched PC, [31:16] zero.
- fetch_valid  out  1  instr_data holds a valid fetch result this cycle.
- ls_req  in  1  load/store request; held with fields stable until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
- ls_signed  in  1  sign-extend load (used only with MEMCTL_SIGNEXT_EN).
- ls_addr  in  ADDR_W  byte address.
- ls_wdata  in  32  store data, right-aligned.
- ls_ack  out  1  one-cycle completion pulse.
- ls_err  out  1  alignment/size error, valid with ls_ack.
- ls_rdata  out  32  load result, right-aligned, valid with ls_ack.
- mem_en, mem_we  out  1  memory enable / write enable.
- mem_addr  out  ADDR_W  word-aligned address ([1:0] = 00).
- mem_be  out  4  byte-lane enables.
- mem_wdata  out  32  lane-steered write data.
- mem_rdata  in  32  read data, one cycle after address.

## Operation
- FSM states: IDLE, FETCH, DATA, RDATA, ERR.
- IDLE: reset state; mem_en=0, stall=1. Goes to FETCH unconditionally next cycle.
- FETCH: mem_en=1, mem_we=0, mem_be=F, mem_addr={pc[ADDR_W-1:2],00}; pc[1] registered as sel_q, fetch_valid registered as 1 next cycle. stall = ls_req.
  - ls_req legal: latch request, go DATA. Illegal (size 11; half with addr[0]=1; word with addr[1:0]≠0): go ERR, no memory access.
- DATA: mem_addr from latched address, mem_we = latched we, stall=1. mem_be: byte 1<<addr[1:0]; half 0011 or 1100 per addr[1]; word 1111. mem_wdata: wdata replicated into the enabled lanes (byte ×4, half ×2). Store: ls_ack=1 this cycle, next FETCH. Load: next RDATA.
- RDATA: ls_rdata = enabled lanes shifted down by addr[1:0]×8, zero-extended; ls_ack=1; stall=1; FETCH address re-issued (mem_en=1); next FETCH.
- ERR: ls_ack=1, ls_err=1, ls_rdata=0, no memory access, stall=1; next FETCH.
- instr_data = sel_q ? {16'h0, mem_rdata[31:16]} : {16'h0, mem_rdata[15:0]}; fetch_valid=0 in cycle after any non-fetch memory cycle.
- Lane order little-endian: byte at addr[1:0]=k lives in bits [8k+7:8k].
- ls_req ignored outside FETCH; requester holds it until ls_ack, and drops it the cycle after ls_ack.

## Timing
- Reset (async): state IDLE; stall=1, mem_en=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, fetch_valid=0, instr_data=0, ls_ack=0, ls_err=0, ls_rdata=0.
- First fetch issued 1 cycle after rst_n release; fetch_valid 1 cycle later.
- Store: req seen cycle N → write at edge N+1, ls_ack in N+1, stall high N..N+1.
- Load: req N → mem read N+1 → ls_ack/ls_rdata N+2, stall high N..N+2; fetch_valid resumes N+3.
- Error: req N → ls_ack+ls_err N+1.
- rst_n asserted mid-access: access abandoned, no ack, no write after reset.

## Configuration
- MEMCTL_SIGNEXT_EN defined: loads with ls_signed=1 sign-extend from bit 7 (byte) or 15 (halfword). Undefined: ls_signed ignored, all loads zero-extend.

## Test plan
- Reset then pc=0x102, memory[0x100]=0x11223344 → mem_addr=0x100, next cycle fetch_valid=1, instr_data=0x00001122.
- Byte store ls_addr=0x101, wdata=0xAB → mem_be=0010, mem_wdata=0xABABABAB, ls_ack in cycle N+1, stall N..N+1.
- Half load 0x102 from 0x11223344 → ls_rdata=0x00001122 at N+2; fetch_valid low N+3? No: high from N+3.
- Byte load 0x103 of 0x80xxxxxx with ls_signed=1 → 0xFFFFFF80 with MEMCTL_SIGNEXT_EN, 0x00000080 without.
- Word load ls_addr=0x102 → ls_ack=1, ls_err=1 at N+1, mem_we/mem_en show no data access.
- rst_n low during DATA of a store → no write, all outputs to reset values, IDLE then FETCH after release.
